// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding and read/write constants for the APB request arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin winner select
//   req : request vector, one bit per requester
//   ptr : index of the previous winner; the search starts at ptr+1 and wraps
//   win : index of the selected requester (0 when nothing is requesting)
//   any : at least one request is pending
module apb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any
);
  logic [PW:0] j;
  // Walk from the farthest candidate back to ptr+1 so the nearest requester is assigned last.
  always_comb begin
    win = '0;
    j = '0;
    any = |req;
    for (int k = NREQ; k >= 1; k--) begin
      j = {1'b0, ptr} + (PW+1)'(k);
      if (j >= (PW+1)'(NREQ)) j = j - (PW+1)'(NREQ);
      if (req[j[PW-1:0]]) win = j[PW-1:0];
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter serialising requester transfers onto an APB bridge port
//   pclk, preset              : clock, synchronous active-high reset
//   req_valid/write/addr/wdata: per-requester requests (addr/wdata packed, requester i at [i*W +: W])
//   req_ready, rsp_valid      : one-hot accept and completion pulses
//   rsp_rdata, rsp_err        : read data and timeout flag, valid with rsp_valid
//   transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr : bridge request side
//   apb_read_data_out, xfer_done : bridge read data and completion strobe
//   Optional macro APB_ARB_TIMEOUT_EN adds a TMO_CYC busy-cycle timeout.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TMO_CYC = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             transfer,
  output logic             read_write,
  output logic [AW-1:0]    apb_write_paddr,
  output logic [DW-1:0]    apb_write_data,
  output logic [AW-1:0]    apb_read_paddr,
  input  logic [DW-1:0]    apb_read_data_out,
  input  logic             xfer_done
);
  localparam int PW = $clog2(NREQ);
  arb_state_e state, state_n;
  logic [PW-1:0] ptr, win, pick;
  logic pick_any, first, cap_rd, tmo, busy, fin;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  apb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .win(pick),
    .any(pick_any)
  );
  assign busy = state == BUSY;
  assign fin  = busy && (xfer_done || tmo);
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
  // Counter sits at zero outside BUSY, so it is already clear on BUSY entry.
  always_ff @(posedge pclk) begin
    if (preset || !busy) cnt <= '0;
    else if (!xfer_done) cnt <= cnt + 1'b1;
  end
  assign tmo = busy && !xfer_done && cnt == CW'(TMO_CYC - 1);
  always_ff @(posedge pclk) begin
    if (preset) rsp_err <= 1'b0;
    else if (fin) rsp_err <= !xfer_done;
  end
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE) ? (pick_any ? BUSY : IDLE) :
              (state == BUSY) ? (fin ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      ptr <= PW'(NREQ - 1);
      win <= '0;
      first <= 1'b0;
      cap_rd <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      first <= state == IDLE && pick_any;
      if (state == IDLE && pick_any) begin
        win <= pick;
        ptr <= pick;
        cap_rd <= ~req_write[pick];
        cap_addr <= req_addr[int'(pick)*AW +: AW];
        cap_wdata <= req_wdata[int'(pick)*DW +: DW];
      end
      // A timeout returns zero data even for a read.
      if (fin) rsp_rdata <= (cap_rd && xfer_done) ? apb_read_data_out : '0;
    end
  end
  always_comb begin
    transfer = busy;
    read_write = (busy && cap_rd) ? RW_READ : RW_WRITE;
    apb_write_paddr = (busy && !cap_rd) ? cap_addr : '0;
    apb_write_data = (busy && !cap_rd) ? cap_wdata : '0;
    apb_read_paddr = (busy && cap_rd) ? cap_addr : '0;
    req_ready = (busy && first) ? NREQ'(1) << win : '0;
    rsp_valid = (state == RESP) ? NREQ'(1) << win : '0;
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scoreboard bench for apb_req_arbiter
module tb_apb_req_arbiter;
  logic pclk = 1'b0;
  logic preset;
  logic [3:0] req_valid, req_write, req_ready, rsp_valid;
  logic [35:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0] rsp_rdata, apb_write_data, apb_read_data_out;
  logic rsp_err, transfer, read_write, xfer_done;
  logic [8:0] apb_write_paddr, apb_read_paddr;
  typedef struct {
    int idx;
    logic [7:0] rdata;
    logic err;
  } rsp_t;
  rsp_t rsp_q[$];
  int gnt_q[$];
  rsp_t r;
  int g;
  int tests = 0;
  int fails = 0;
  apb_req_arbiter dut (
    .pclk(pclk),
    .preset(preset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .transfer(transfer),
    .read_write(read_write),
    .apb_write_paddr(apb_write_paddr),
    .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr),
    .apb_read_data_out(apb_read_data_out),
    .xfer_done(xfer_done)
  );
  always #5 pclk = ~pclk;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic tick();
    @(negedge pclk);
  endtask
  task automatic set_req(input int i, input logic wr, input logic [8:0] a, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*9 +: 9] = a;
    req_wdata[i*8 +: 8] = d;
  endtask
  task automatic wait_xfer();
    int n = 0;
    while (!transfer && n < 20) begin
      tick();
      n++;
    end
    if (!transfer) check("wait_transfer_timeout", 0, 1);
  endtask
  always @(negedge pclk) begin
    if (req_ready != 0) begin
      if (gnt_q.size() == 0) check("grant_unexpected", 32'(req_ready), 0);
      else begin
        g = gnt_q.pop_front();
        check("grant_onehot", 32'(req_ready), 32'(1) << g);
      end
    end
    if (rsp_valid != 0) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        r = rsp_q.pop_front();
        check("rsp_onehot", 32'(rsp_valid), 32'(1) << r.idx);
        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
        check("rsp_err", 32'(rsp_err), 32'(r.err));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int e;
    preset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    apb_read_data_out = '0;
    xfer_done = 1'b0;
    tick();
    tick();
    check("rst_transfer", 32'(transfer), 0);
    check("rst_rw", 32'(read_write), 0);
    check("rst_addrs", 32'({apb_write_paddr, apb_read_paddr}), 0);
    check("rst_wdata", 32'(apb_write_data), 0);
    check("rst_handshake", 32'({req_ready, rsp_valid}), 0);
    check("rst_rsp", 32'({rsp_rdata, rsp_err}), 0);
    preset = 1'b0;
    tick();
    // single write from requester 2, zero-wait bridge
    set_req(2, 1'b1, 9'h1A5, 8'h3C);
    gnt_q.push_back(2);
    rsp_q.push_back('{idx: 2, rdata: 8'h00, err: 1'b0});
    apb_read_data_out = 8'hEE;
    tick();
    check("wr_transfer", 32'(transfer), 1);
    check("wr_rw", 32'(read_write), 0);
    check("wr_paddr", 32'(apb_write_paddr), 32'h1A5);
    check("wr_data", 32'(apb_write_data), 32'h3C);
    check("wr_rpaddr", 32'(apb_read_paddr), 0);
    req_valid = '0;
    xfer_done = 1'b1;
    tick();
    check("wr_rsp_time", 32'(rsp_valid), 32'h4);
    check("wr_resp_transfer", 32'(transfer), 0);
    xfer_done = 1'b0;
    apb_read_data_out = '0;
    tick();
    // single read from requester 0, three wait cycles
    set_req(0, 1'b0, 9'h045, 8'h00);
    gnt_q.push_back(0);
    rsp_q.push_back('{idx: 0, rdata: 8'h7E, err: 1'b0});
    tick();
    check("rd_rw", 32'(read_write), 1);
    check("rd_paddr", 32'(apb_read_paddr), 32'h045);
    check("rd_wpaddr", 32'({apb_write_paddr, apb_write_data}), 0);
    req_valid = '0;
    tick();
    tick();
    check("rd_stable", 32'({transfer, read_write, apb_read_paddr}), 32'({2'b11, 9'h045}));
    tick();
    xfer_done = 1'b1;
    apb_read_data_out = 8'h7E;
    tick();
    check("rd_rsp_time", 32'(rsp_valid), 32'h1);
    xfer_done = 1'b0;
    apb_read_data_out = '0;
    tick();
    // all four requesting continuously from reset; odd requesters write
    preset = 1'b1;
    tick();
    preset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, i % 2 == 1, 9'(9'h100 + i), 8'(8'hA0 + i));
    for (int n = 0; n < 5; n++) begin
      gnt_q.push_back(order[n]);
      rsp_q.push_back('{idx: order[n], rdata: (order[n] % 2 == 1) ? 8'h00 : 8'(8'h10 + order[n]), err: 1'b0});
    end
    for (int n = 0; n < 5; n++) begin
      e = order[n];
      wait_xfer();
      check("rr_addr", 32'(apb_write_paddr | apb_read_paddr), 32'h100 + e);
      check("rr_rw", 32'(read_write), (e % 2 == 0) ? 1 : 0);
      if (e % 2 == 1) check("rr_wdata", 32'(apb_write_data), 32'hA0 + e);
      xfer_done = 1'b1;
      apb_read_data_out = (e % 2 == 1) ? 8'hEE : 8'(8'h10 + e);
      tick();
      xfer_done = 1'b0;
      apb_read_data_out = '0;
      tick();
      if (n == 4) req_valid = '0;
    end
    // reset in the second BUSY cycle aborts the transfer
    set_req(2, 1'b1, 9'h0F0, 8'h11);
    gnt_q.push_back(2);
    tick();
    req_valid = '0;
    tick();
    check("abort_busy2", 32'(transfer), 1);
    preset = 1'b1;
    tick();
    check("abort_transfer", 32'(transfer), 0);
    check("abort_no_rsp", 32'(rsp_valid), 0);
    preset = 1'b0;
    set_req(0, 1'b1, 9'h0AA, 8'h55);
    set_req(3, 1'b1, 9'h133, 8'h66);
    gnt_q.push_back(0);
    rsp_q.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
    tick();
    check("post_rst_winner", 32'(apb_write_paddr), 32'h0AA);
    req_valid = '0;
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    tick();
    // xfer_done pulsed while idle with no requests
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check("idle_quiet", 32'({transfer, read_write, req_ready, rsp_valid, rsp_rdata}), 0);
      tick();
    end
`ifdef APB_ARB_TIMEOUT_EN
    begin
      int cnt = 0;
      set_req(3, 1'b0, 9'h1FF, 8'h00);
      gnt_q.push_back(3);
      rsp_q.push_back('{idx: 3, rdata: 8'h00, err: 1'b1});
      apb_read_data_out = 8'hAB;
      tick();
      req_valid = '0;
      while (transfer && cnt < 40) begin
        cnt++;
        tick();
      end
      check("tmo_cycles", cnt, 16);
      check("tmo_rsp", 32'(rsp_valid), 32'h8);
      apb_read_data_out = '0;
      tick();
    end
`endif
    tick();
    check("gnt_q_empty", gnt_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
